gamepad_pmod_tx: RTL and testbench

Serial transmitter for the gamepad PMOD link: it drives `pmod_data`, `pmod_clk` and `pmod_latch` so that the existing gamepad PMOD receiver reconstructs a button word. It serves as a bench stimulus generator for the receive path and as the link's driving end in the two-board build. It snapshots a parallel button word, shifts it out MSB first with a divided clock, pulses latch, then idles for a programmable gap.

---
 rtl/gamepad_pmod_tx.sv | 141 ++++++++++++++
 tb/tb_gamepad_pmod_tx.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/gamepad_pmod_tx.sv
// Gamepad PMOD link transmitter: snapshots a button word, shifts it out MSB first
// on a divided clock, pulses latch, then idles for a programmable gap.
module gamepad_pmod_tx #(
    parameter int unsigned BIT_WIDTH  = 12,
    parameter int unsigned CLK_DIV    = 4,
    parameter int unsigned GAP_CYCLES = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [BIT_WIDTH-1:0] buttons,
    input  logic                 present,
    input  logic                 send,
    input  logic                 auto_en,
    output logic                 busy,
    output logic                 frame_done,
    output logic                 pmod_data,
    output logic                 pmod_clk,
    output logic                 pmod_latch
);

    localparam int unsigned HW = $clog2(CLK_DIV);
    localparam int unsigned IW = $clog2(BIT_WIDTH);
    localparam int unsigned GW = $clog2(GAP_CYCLES + 1);

    localparam logic [HW-1:0] HALF_LOAD = HW'(CLK_DIV - 1);
    localparam logic [IW-1:0] IDX_LOAD  = IW'(BIT_WIDTH - 1);
    localparam logic [GW-1:0] GAP_LOAD  = GW'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, BIT_LO, BIT_HI, LATCH, GAP} state_t;

    state_t               state_q, state_d;
    logic [HW-1:0]        half_q, half_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [GW-1:0]        gap_q, gap_d;
    logic [BIT_WIDTH-1:0] snap_q, snap_d;
    logic                 busy_q, busy_d;
    logic                 frame_done_q, frame_done_d;
    logic                 pmod_data_q, pmod_data_d;
    logic                 pmod_clk_q, pmod_clk_d;
    logic                 pmod_latch_q, pmod_latch_d;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
        state_d      = state_q;
        half_d       = half_q;
        idx_d        = idx_q;
        gap_d        = gap_q;
        snap_d       = snap_q;
        frame_done_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (send || auto_en) begin
                    snap_d  = present ? buttons : {BIT_WIDTH{1'b1}};
                    idx_d   = IDX_LOAD;
                    half_d  = HALF_LOAD;
                    state_d = BIT_LO;
                end
            end
            BIT_LO: begin
                if (half_q == '0) begin
                    half_d  = HALF_LOAD;
                    state_d = BIT_HI;
                end else begin
                    half_d = half_q - HW'(1);
                end
            end
            BIT_HI: begin
                if (half_q == '0) begin
                    half_d = HALF_LOAD;
                    if (idx_q == '0) begin
                        state_d = LATCH;
                    end else begin
                        idx_d   = idx_q - IW'(1);
                        state_d = BIT_LO;
                    end
                end else begin
                    half_d = half_q - HW'(1);
                end
            end
            LATCH: begin
                if (half_q == '0) begin
                    gap_d   = GAP_LOAD;
                    state_d = GAP;
                end else begin
                    half_d = half_q - HW'(1);
                end
            end
            GAP: begin
                if (gap_q == '0) begin
                    state_d      = IDLE;
                    frame_done_d = 1'b1;
                end else begin
                    gap_d = gap_q - GW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs are decoded from the next state so the registered pins line up with it.
        busy_d       = (state_d != IDLE);
        pmod_clk_d   = (state_d == BIT_HI);
        pmod_latch_d = (state_d == LATCH);
        pmod_data_d  = ((state_d == BIT_LO) || (state_d == BIT_HI)) ? snap_d[idx_d] : 1'b0;
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments here so every flop samples pre-edge values.
        if (reset) begin
            // NOTE: the snapshot register is cleared too; it is a plain register, not a RAM.
            state_q      <= IDLE;
            half_q       <= '0;
            idx_q        <= '0;
            gap_q        <= '0;
            snap_q       <= '0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            pmod_data_q  <= 1'b0;
            pmod_clk_q   <= 1'b0;
            pmod_latch_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            half_q       <= half_d;
            idx_q        <= idx_d;
            gap_q        <= gap_d;
            snap_q       <= snap_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            pmod_data_q  <= pmod_data_d;
            pmod_clk_q   <= pmod_clk_d;
            pmod_latch_q <= pmod_latch_d;
        end
    end

    assign busy       = busy_q;
    assign frame_done = frame_done_q;
    assign pmod_data  = pmod_data_q;
    assign pmod_clk   = pmod_clk_q;
    assign pmod_latch = pmod_latch_q;

endmodule

// File: tb/tb_gamepad_pmod_tx.sv
// Bench for gamepad_pmod_tx: a behavioural PMOD receiver feeds a scoreboard of
// expected words, plus frame timing checks relative to the acceptance edge.
module tb_gamepad_pmod_tx;

    localparam int BW   = 12;
    localparam int HALF = 4;
    localparam int GAP  = 8;
    localparam int T_RISE  = HALF;                     // edges from acceptance to first pmod_clk high
    localparam int T_LATCH = 2 * BW * HALF;            // 96
    localparam int T_DONE  = (2 * BW + 1) * HALF + GAP; // 108
    localparam int PERIOD  = T_DONE + 1;               // 109

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [BW-1:0] buttons = '0;
    logic          present = 1'b1;
    logic          send = 1'b1;
    logic          auto_en = 1'b0;
    logic          busy, frame_done, pmod_data, pmod_clk, pmod_latch;

    gamepad_pmod_tx #(.BIT_WIDTH(BW), .CLK_DIV(HALF), .GAP_CYCLES(GAP)) dut (
        .clk        (clk),
        .reset      (reset),
        .buttons    (buttons),
        .present    (present),
        .send       (send),
        .auto_en    (auto_en),
        .busy       (busy),
        .frame_done (frame_done),
        .pmod_data  (pmod_data),
        .pmod_clk   (pmod_clk),
        .pmod_latch (pmod_latch)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    // Receiver model and monitor state (written only by the monitor process).
    logic [BW-1:0] exp_q[$];
    logic [BW-1:0] shreg = '0;
    logic [BW-1:0] rx_word = '0;
    int cyc = 0, rises = 0, first_rise_cyc = 0, latch_cyc = 0, done_cyc = 0;
    int latch_cnt = 0, done_cnt = 0;
    logic prev_clk = 1'b0, prev_latch = 1'b0, prev_data = 1'b0;

    always begin
        @(posedge clk);
        cyc++;
        #1;
        if (reset) begin
            rises = 0;
        end else begin
            if (pmod_data !== prev_data) check("data_stable_clk", {31'd0, pmod_clk}, 32'd0);
            if (pmod_clk && !prev_clk) begin
                shreg = {shreg[BW-2:0], pmod_data};
                rises++;
                if (rises == 1) first_rise_cyc = cyc;
            end
            if (pmod_latch && !prev_latch) begin
                latch_cnt++;
                latch_cyc = cyc;
                rx_word   = shreg;
                check("bit_count", rises, BW);
                rises = 0;
                if (exp_q.size() == 0) check("latch_unexpected", 32'd1, 32'd0);
                else check("rx_word", {20'd0, rx_word}, {20'd0, exp_q.pop_front()});
            end
            if (frame_done) begin
                done_cnt++;
                done_cyc = cyc;
                check("busy_at_done", {31'd0, busy}, 32'd0);
            end
        end
        prev_clk   = pmod_clk;
        prev_latch = pmod_latch;
        prev_data  = pmod_data;
    end

    int t_acc = 0;

    task automatic start_frame(input logic [BW-1:0] btn, input logic pres);
        @(negedge clk);
        buttons = btn;
        present = pres;
        send    = 1'b1;
        t_acc   = cyc + 1;
        exp_q.push_back(pres ? btn : {BW{1'b1}});
        @(negedge clk);
        send = 1'b0;
        check("busy_start", {31'd0, busy}, 32'd1);
    endtask

    task automatic wait_done();
        int start = done_cnt;
        for (int i = 0; i < 400 && done_cnt == start; i++) @(negedge clk);
        if (done_cnt == start) check("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic check_timing(input string tag);
        check({tag, "_rise"},  first_rise_cyc - t_acc, T_RISE);
        check({tag, "_latch"}, latch_cyc - t_acc, T_LATCH);
        check({tag, "_done"},  done_cyc - t_acc, T_DONE);
    endtask

    task automatic check_idle_outputs(input string tag);
        check(tag, {27'd0, busy, frame_done, pmod_data, pmod_clk, pmod_latch}, 32'd0);
    endtask

    function automatic logic rx_present();
        return rx_word != {BW{1'b1}};
    endfunction

    function automatic logic [BW-1:0] rx_buttons();
        return rx_present() ? rx_word : '0;
    endfunction

    initial begin
        int l0, d0, prev_latch_cyc;
        logic [BW-1:0] prev_word;

        // Reset held for 3 cycles with send high: outputs stay 0.
        buttons = 12'h5A5;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #2;
            check_idle_outputs("reset_outputs");
        end
        @(negedge clk);
        reset = 1'b0;
        t_acc = cyc + 1;
        exp_q.push_back(12'h5A5);
        @(negedge clk);
        send = 1'b0;
        check("busy_after_reset", {31'd0, busy}, 32'd1);
        wait_done();
        check_timing("reset_frame");

        // Loopback with 12'hA53.
        start_frame(12'hA53, 1'b1);
        wait_done();
        check_timing("a53");
        check("a53_present", {31'd0, rx_present()}, 32'd1);
        check("a53_buttons", {20'd0, rx_buttons()}, 32'hA53);
        check("a53_b", {31'd0, rx_buttons()[11]}, 32'd1);
        check("a53_r", {31'd0, rx_buttons()[0]}, 32'd1);

        // Absent controller.
        start_frame(12'h000, 1'b0);
        wait_done();
        check("absent_present", {31'd0, rx_present()}, 32'd0);
        check("absent_buttons", {20'd0, rx_buttons()}, 32'd0);

        // Request and input changes mid-frame are ignored.
        l0 = latch_cnt;
        d0 = done_cnt;
        start_frame(12'h3C5, 1'b1);
        while (cyc < t_acc + 19) @(negedge clk);
        send    = 1'b1;
        buttons = 12'hC3A;
        present = 1'b0;
        @(negedge clk);
        send = 1'b0;
        wait_done();
        repeat (20) @(negedge clk);
        check("ignored_latches", latch_cnt - l0, 1);
        check("ignored_dones", done_cnt - d0, 1);
        check("ignored_word", {20'd0, rx_word}, 32'h3C5);

        // Auto mode: back-to-back frames, alternating words.
        @(negedge clk);
        buttons = 12'h001;
        present = 1'b1;
        auto_en = 1'b1;
        t_acc   = cyc + 1;
        exp_q.push_back(12'h001);
        prev_latch_cyc = 0;
        for (int k = 0; k < 4; k++) begin
            wait_done();
            check_timing("auto");
            if (k > 0) check("latch_period", latch_cyc - prev_latch_cyc, PERIOD);
            prev_latch_cyc = latch_cyc;
            check("auto_word", {20'd0, rx_word}, (k % 2 == 0) ? 32'h001 : 32'h800);
            if (k < 3) begin
                buttons = (k % 2 == 0) ? 12'h800 : 12'h001;
                t_acc   = cyc + 1;
                exp_q.push_back(buttons);
            end else begin
                auto_en = 1'b0;
            end
        end
        repeat (5) @(negedge clk);

        // Reset mid-frame: no latch, receiver keeps its word.
        prev_word = rx_word;
        l0 = latch_cnt;
        start_frame(12'hFFE, 1'b1);
        while (cyc < t_acc + 39) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_idle_outputs("abort_outputs");
        reset = 1'b0;
        exp_q.delete();
        repeat (150) @(negedge clk);
        check("abort_no_latch", latch_cnt - l0, 0);
        check("abort_word_kept", {20'd0, rx_word}, {20'd0, prev_word});

        start_frame(12'hFFE, 1'b1);
        wait_done();
        check_timing("after_abort");
        check("after_abort_word", {20'd0, rx_word}, 32'hFFE);
        check("queue_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
